ab_stream_source: RTL and testbench
===================================

Name: ab_stream_source

Overview:
- Host-side transmitter feeding the accelerator's two input streams: activation stream A (a_input/a_valid/a_ready) and weight stream B (b_input/b_valid/b_ready).
- Fetches words from one shared synchronous host-memory read port and buffers them in a per-stream FIFO.
- Presents the buffered words under a valid/ready handshake, in address order, for a programmed length per stream.
- Sits in the testbench/SoC wrapper, directly upstream of the accelerator top.

Parameters:
- IO_DATA_WIDTH, 16, stream word width and memory word width.
- LOG2_OF_MEM_HEIGHT, 20, host-memory address width.
- COUNT_WIDTH, 32, width of the programmed per-stream length.
- FIFO_DEPTH, 4, entries per stream FIFO; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- arst_n_in  in  1  reset.
- start  in  1  launch pulse; sampled only in IDLE.
- a_base_addr  in  LOG2_OF_MEM_HEIGHT  first A word address; latched on start.
- a_count  in  COUNT_WIDTH  number of A words; latched on start.
- b_base_addr  in  LOG2_OF_MEM_HEIGHT  first B word address; latched on start.
- b_count  in  COUNT_WIDTH  number of B words; latched on start.
- mem_read_addr  out  LOG2_OF_MEM_HEIGHT  host-memory read address.
- mem_re  out  1  host-memory read enable; data returns next cycle.
- mem_qout  in  IO_DATA_WIDTH  host-memory read data.
- a_input  out  IO_DATA_WIDTH  A word; equals the A FIFO head.
- a_valid  out  1  A word available.
- a_ready  in  1  consumer accepts A.
- b_input  out  IO_DATA_WIDTH  B word; equals the B FIFO head.
- b_valid  out  1  B word available.
- b_ready  in  1  consumer accepts B.
- running  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a job completes.
- a_stall_cycles  out  32  see Optional Feature.
- b_stall_cycles  out  32  see Optional Feature.

Behaviour:
- Clocking and reset: one clock, clk; reset arst_n_in is asynchronous, active-low.
- Reset values: state IDLE, FIFOs empty, in-flight tag cleared, round-robin pointer set to favour A.
- Outputs under reset: mem_re, a_valid, b_valid, running, done, mem_read_addr, a_input, b_input and both stall counters are all 0.
- Reset mid-job: the job is aborted, in-flight read data is discarded, and no done pulse is produced.
- FSM IDLE -> STREAM: on start while in IDLE. Latches the bases and counts; remaining counters are set to the counts; index counters are set to 0.
- FSM STREAM -> DRAIN: when both remaining counters are 0.
- FSM DRAIN -> IDLE: when both FIFOs are empty and no read is in flight. done=1 in the first IDLE cycle.
- start outside IDLE is ignored.
- Read issue (STREAM only): at most one read per cycle.
  - A stream is eligible when remaining>0 and FIFO occupancy plus in-flight reads to that stream is less than FIFO_DEPTH.
  - Both eligible: round-robin, alternating, with the pointer updated on each grant.
  - Exactly one eligible: that stream is granted.
  - None eligible: mem_re=0.
- Addressing: granted address = base + index, modulo 2^LOG2_OF_MEM_HEIGHT (wrap-around allowed). On a grant, index increments and remaining decrements.
- Read latency: read at cycle t; mem_qout is valid at t+1 and written into the FIFO of the stream recorded in a registered 1-bit tag at the t+1 edge; the corresponding valid is high from t+2.
- Zero-length streams: a stream with count 0 is never granted.
  - Both counts 0: start at edge 0 gives STREAM in cycle 1, DRAIN in cycle 2, done in cycle 3.
- Handshake:
  - valid = FIFO not empty.
  - Transfer happens when valid and ready are both high.
  - While valid is high and ready is low, the data is held stable.
  - valid never drops without a transfer.
  - A push and a pop on the same FIFO in the same cycle are both allowed and leave occupancy unchanged.
- Full FIFO: guaranteed never to overflow by the credit rule; no write is ever dropped.
- Throughput: one word per cycle per stream is sustainable only with FIFO_DEPTH≥2 and a single active stream. With both streams active the shared read port limits the aggregate to one word per cycle.

Optional Feature:
- Macro: AB_SOURCE_STATS_EN.
- Defined:
  - a_stall_cycles increments in each cycle with a_valid=1 and a_ready=0; b_stall_cycles does the same for B.
  - Both are 32-bit, saturating at 2^32-1, and cleared on reset and on an accepted start.
- Undefined: the counter logic is absent and both ports are tied to 0.

Decomposition:
- Package conv_stream_pkg: state enum (IDLE, STREAM, DRAIN), stream tag enum (STREAM_A, STREAM_B), saturating-counter max constant.
- Sub-module stream_fifo: synchronous FIFO with depth FIFO_DEPTH and width IO_DATA_WIDTH. It provides push, pop, head, empty and an occupancy count. ab_stream_source instantiates it twice.

Test Plan:
- Basic A only: a_base=0x100, a_count=3, b_count=0, mem[0x100..0x102]={7,8,9}, a_ready=1 -> a_input sequence 7,8,9; first a_valid 3 cycles after the start edge; done pulses once; running falls.
- Backpressure: a_count=6, b_count=6, a_ready low for 10 cycles -> mem_re never raises A occupancy plus in-flight above 4; B continues streaming; every A word is delivered once, in order, with stable data while stalled.
- Arbitration: a_count=b_count=4, both ready=1 -> mem_read_addr alternates A,B,A,B starting with A; 8 reads issued in 8 consecutive cycles.
- Wrap and zero length: a_base=2^20-1, a_count=2 -> reads at 0xFFFFF then 0x00000. A separate run with both counts 0 -> done in cycle 3 and no mem_re.
- Reset and ignored start: assert arst_n_in mid-STREAM -> all outputs 0 immediately, no done pulse. A start pulse during STREAM -> latched values unchanged.
- Stats (AB_SOURCE_STATS_EN defined): a_count=1, a_ready held low 5 cycles after a_valid rises -> a_stall_cycles=5. With the macro undefined -> the counter reads 0.

Source files
------------

// File: rtl/conv_stream_pkg.sv
// Shared types for the A/B stream source: FSM states, stream tags and the stall-counter ceiling.
package conv_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  typedef enum logic {
    STREAM_A = 1'b0,
    STREAM_B = 1'b1
  } stream_tag_e;

  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == STALL_CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Single-clock FIFO, DEPTH a power of two: head visible the cycle after the push edge.
// Push and pop may coincide; the caller's credit scheme guarantees a push never meets a full FIFO.
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         arst_n_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_dat_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ab_stream_source.sv
// Feeds streams A and B from one shared 1-cycle-latency memory port through credit-guarded FIFOs.
// A word appears on its stream 2 cycles after its read; AB_SOURCE_STATS_EN adds the stall counters.
module ab_stream_source
  import conv_stream_pkg::*;
#(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int COUNT_WIDTH        = 32,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          start,
  input  logic [LOG2_OF_MEM_HEIGHT-1:0] a_base_addr,
  input  logic [COUNT_WIDTH-1:0]        a_count,
  input  logic [LOG2_OF_MEM_HEIGHT-1:0] b_base_addr,
  input  logic [COUNT_WIDTH-1:0]        b_count,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
  output logic                          mem_re,
  input  logic [IO_DATA_WIDTH-1:0]      mem_qout,
  output logic [IO_DATA_WIDTH-1:0]      a_input,
  output logic                          a_valid,
  input  logic                          a_ready,
  output logic [IO_DATA_WIDTH-1:0]      b_input,
  output logic                          b_valid,
  input  logic                          b_ready,
  output logic                          running,
  output logic                          done,
  output logic [31:0]                   a_stall_cycles,
  output logic [31:0]                   b_stall_cycles
);
  localparam int AW    = LOG2_OF_MEM_HEIGHT;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

  state_e                 state_q;
  logic [AW-1:0]          a_base_q, b_base_q;
  logic [AW-1:0]          a_idx_q, b_idx_q;
  logic [COUNT_WIDTH-1:0] a_rem_q, b_rem_q;
  logic                   infl_vld_q;
  stream_tag_e            infl_tag_q;
  stream_tag_e            rr_q;
  logic                   done_q;

  logic                     start_acc;
  logic                     a_push, b_push, a_pop, b_pop;
  logic                     a_empty, b_empty;
  logic [IO_DATA_WIDTH-1:0] a_head, b_head;
  logic [OCC_W-1:0]         a_occ, b_occ;
  logic [OCC_W-1:0]         a_pend, b_pend;
  logic                     a_elig, b_elig, grant_vld;
  stream_tag_e              grant_tag;
  logic [AW-1:0]            grant_addr;

  assign start_acc = (state_q == IDLE) && start;

  // The single in-flight read is the only one not yet visible in a FIFO count.
  assign a_push = infl_vld_q && (infl_tag_q == STREAM_A);
  assign b_push = infl_vld_q && (infl_tag_q == STREAM_B);
  assign a_pop  = a_valid && a_ready;
  assign b_pop  = b_valid && b_ready;

  stream_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(IO_DATA_WIDTH)) u_fifo_a (
    .clk_i      (clk),
    .arst_n_i   (arst_n_in),
    .push_i     (a_push),
    .push_dat_i (mem_qout),
    .pop_i      (a_pop),
    .head_o     (a_head),
    .empty_o    (a_empty),
    .count_o    (a_occ)
  );

  stream_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(IO_DATA_WIDTH)) u_fifo_b (
    .clk_i      (clk),
    .arst_n_i   (arst_n_in),
    .push_i     (b_push),
    .push_dat_i (mem_qout),
    .pop_i      (b_pop),
    .head_o     (b_head),
    .empty_o    (b_empty),
    .count_o    (b_occ)
  );

  always_comb begin
    a_pend    = a_occ + OCC_W'(a_push);
    b_pend    = b_occ + OCC_W'(b_push);
    a_elig    = (state_q == STREAM) && (a_rem_q != '0) && (a_pend < DEPTH_OCC);
    b_elig    = (state_q == STREAM) && (b_rem_q != '0) && (b_pend < DEPTH_OCC);
    grant_vld = a_elig || b_elig;
    grant_tag = STREAM_A;
    if (a_elig && b_elig) grant_tag = rr_q;
    else if (b_elig)      grant_tag = STREAM_B;
    grant_addr = (grant_tag == STREAM_A) ? (a_base_q + a_idx_q) : (b_base_q + b_idx_q);
  end

  assign mem_re        = grant_vld;
  assign mem_read_addr = grant_vld ? grant_addr : '0;
  assign a_valid       = !a_empty;
  assign b_valid       = !b_empty;
  assign a_input       = a_empty ? '0 : a_head;
  assign b_input       = b_empty ? '0 : b_head;
  assign running       = (state_q != IDLE);
  assign done          = done_q;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q    <= IDLE;
      a_base_q   <= '0;
      b_base_q   <= '0;
      a_idx_q    <= '0;
      b_idx_q    <= '0;
      a_rem_q    <= '0;
      b_rem_q    <= '0;
      infl_vld_q <= 1'b0;
      infl_tag_q <= STREAM_A;
      rr_q       <= STREAM_A;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      infl_vld_q <= grant_vld;
      infl_tag_q <= grant_tag;
      if (grant_vld) begin
        rr_q <= (grant_tag == STREAM_A) ? STREAM_B : STREAM_A;
        if (grant_tag == STREAM_A) begin
          a_idx_q <= a_idx_q + AW'(1);
          a_rem_q <= a_rem_q - COUNT_WIDTH'(1);
        end else begin
          b_idx_q <= b_idx_q + AW'(1);
          b_rem_q <= b_rem_q - COUNT_WIDTH'(1);
        end
      end
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            a_base_q <= a_base_addr;
            b_base_q <= b_base_addr;
            a_rem_q  <= a_count;
            b_rem_q  <= b_count;
            a_idx_q  <= '0;
            b_idx_q  <= '0;
            state_q  <= STREAM;
          end
        end
        STREAM: begin
          if ((a_rem_q == '0) && (b_rem_q == '0)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (a_empty && b_empty && !infl_vld_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AB_SOURCE_STATS_EN
  logic [31:0] a_stall_q, b_stall_q;
  logic [31:0] a_stall_d, b_stall_d;

  always_comb begin
    a_stall_d = a_stall_q;
    b_stall_d = b_stall_q;
    if (start_acc) begin
      a_stall_d = '0;
      b_stall_d = '0;
    end else begin
      if (a_valid && !a_ready) a_stall_d = sat_inc(a_stall_q);
      if (b_valid && !b_ready) b_stall_d = sat_inc(b_stall_q);
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      a_stall_q <= '0;
      b_stall_q <= '0;
    end else begin
      a_stall_q <= a_stall_d;
      b_stall_q <= b_stall_d;
    end
  end

  assign a_stall_cycles = a_stall_q;
  assign b_stall_cycles = b_stall_q;
`else
  assign a_stall_cycles = '0;
  assign b_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ab_stream_source.sv
// Randomised and directed bench for ab_stream_source against a word-list / credit reference model.
module tb_ab_stream_source;
  localparam int DW    = 16;
  localparam int AW    = 20;
  localparam int CW    = 32;
  localparam int DEPTH = 4;
`ifdef AB_SOURCE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst_n_in;
  logic          start;
  logic [AW-1:0] a_base_addr, b_base_addr;
  logic [CW-1:0] a_count, b_count;
  logic [AW-1:0] mem_read_addr;
  logic          mem_re;
  logic [DW-1:0] mem_qout;
  logic [DW-1:0] a_input, b_input;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic          running, done;
  logic [31:0]   a_stall_cycles, b_stall_cycles;

  always #5 clk = ~clk;

  ab_stream_source dut (
    .clk            (clk),
    .arst_n_in      (arst_n_in),
    .start          (start),
    .a_base_addr    (a_base_addr),
    .a_count        (a_count),
    .b_base_addr    (b_base_addr),
    .b_count        (b_count),
    .mem_read_addr  (mem_read_addr),
    .mem_re         (mem_re),
    .mem_qout       (mem_qout),
    .a_input        (a_input),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .b_input        (b_input),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .running        (running),
    .done           (done),
    .a_stall_cycles (a_stall_cycles),
    .b_stall_cycles (b_stall_cycles)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  logic [DW-1:0] mem_ovr [int];

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] addr);
    if (mem_ovr.exists(int'(addr))) return mem_ovr[int'(addr)];
    return (addr[15:0] * 16'd40503) ^ {12'h000, addr[19:16]};
  endfunction

  // Host memory: synchronous read, data one cycle after mem_re.
  always @(posedge clk) if (mem_re) mem_qout <= memval(mem_read_addr);

  logic [DW-1:0] exp_a[$], exp_b[$];
  logic [AW-1:0] a_base_m, b_base_m;
  int            a_cnt_m, b_cnt_m, iss_a, iss_b, dlv_a, dlv_b;
  bit            last_b;
  int            stall_a_m, stall_b_m;
  bit            a_hold, b_hold;
  logic [DW-1:0] a_hold_dat, b_hold_dat;
  int            a_pct, b_pct, a_block, b_block;
  int            done_cnt, done_cyc, first_a_cyc, dlv_b_at10;
  bit            rd_tag[$];
  int            rd_cyc[$];
  logic [AW-1:0] rd_addr[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    arst_n_in = 1'b0;
    start     = 1'b0;
    #1;
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_addr", mem_read_addr, 0);
    check("rst_a_valid", a_valid, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_a_input", a_input, 0);
    check("rst_b_input", b_input, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_a_stall", a_stall_cycles, 0);
    check("rst_b_stall", b_stall_cycles, 0);
    repeat (2) @(negedge clk);
    arst_n_in = 1'b1;
    a_hold = 1'b0;
    b_hold = 1'b0;
    last_b = 1'b1;
  endtask

  task automatic step(input int k, input bit glitch);
    bit            ea, eb, is_a, known;
    logic [AW-1:0] na, nb;
    @(negedge clk);
    start = glitch;
    if (glitch) begin
      a_base_addr = AW'($urandom);
      b_base_addr = AW'($urandom);
      a_count     = CW'($urandom_range(1, 40));
      b_count     = CW'($urandom_range(1, 40));
    end
    a_ready = (k >= a_block) && ($urandom_range(0, 99) < a_pct);
    b_ready = (k >= b_block) && ($urandom_range(0, 99) < b_pct);

    if (a_hold) begin
      check("a_hold_valid", a_valid, 1);
      check("a_hold_data", a_input, a_hold_dat);
    end
    if (b_hold) begin
      check("b_hold_valid", b_valid, 1);
      check("b_hold_data", b_input, b_hold_dat);
    end

    ea = (iss_a < a_cnt_m) && (iss_a - dlv_a < DEPTH);
    eb = (iss_b < b_cnt_m) && (iss_b - dlv_b < DEPTH);
    na = a_base_m + AW'(iss_a);
    nb = b_base_m + AW'(iss_b);
    if (ea || eb) check("mem_re_when_eligible", mem_re, 1);
    if (mem_re) begin
      is_a  = (iss_a < a_cnt_m) && (mem_read_addr == na);
      known = is_a || ((iss_b < b_cnt_m) && (mem_read_addr == nb));
      check("read_addr_expected", known, 1);
      if (known) begin
        check("read_credit", is_a ? ea : eb, 1);
        if (ea && eb) check("rr_grant_is_a", is_a, last_b);
        last_b = !is_a;
        rd_tag.push_back(!is_a);
        rd_cyc.push_back(k);
        rd_addr.push_back(mem_read_addr);
        if (is_a) iss_a++;
        else      iss_b++;
      end
    end

    if (a_valid && first_a_cyc < 0) first_a_cyc = k;
    if (a_valid && exp_a.size() == 0) check("a_spurious_valid", a_valid, 0);
    else if (a_valid && a_ready) begin
      check("a_data", a_input, exp_a.pop_front());
      dlv_a++;
    end
    if (b_valid && exp_b.size() == 0) check("b_spurious_valid", b_valid, 0);
    else if (b_valid && b_ready) begin
      check("b_data", b_input, exp_b.pop_front());
      dlv_b++;
    end

    if (done) begin
      done_cnt++;
      if (done_cyc < 0) begin
        done_cyc = k;
        check("running_at_done", running, 0);
        check("a_stall_at_done", a_stall_cycles, STATS ? stall_a_m : 0);
        check("b_stall_at_done", b_stall_cycles, STATS ? stall_b_m : 0);
      end
    end else if (done_cyc < 0) begin
      check("running_in_job", running, 1);
    end

    a_hold     = a_valid && !a_ready;
    a_hold_dat = a_input;
    b_hold     = b_valid && !b_ready;
    b_hold_dat = b_input;
    if (a_hold) stall_a_m++;
    if (b_hold) stall_b_m++;
  endtask

  task automatic init_job(input logic [AW-1:0] abase, input int acnt,
                          input logic [AW-1:0] bbase, input int bcnt,
                          input int apct, input int bpct, input int ablk, input int bblk);
    a_base_m = abase;  a_cnt_m = acnt;
    b_base_m = bbase;  b_cnt_m = bcnt;
    exp_a.delete();
    exp_b.delete();
    for (int i = 0; i < acnt; i++) exp_a.push_back(memval(abase + AW'(i)));
    for (int i = 0; i < bcnt; i++) exp_b.push_back(memval(bbase + AW'(i)));
    iss_a = 0; iss_b = 0; dlv_a = 0; dlv_b = 0;
    stall_a_m = 0; stall_b_m = 0;
    done_cnt = 0; done_cyc = -1; first_a_cyc = -1; dlv_b_at10 = -1;
    rd_tag.delete(); rd_cyc.delete(); rd_addr.delete();
    a_pct = apct; b_pct = bpct; a_block = ablk; b_block = bblk;
    @(negedge clk);
    start       = 1'b1;
    a_base_addr = abase;
    a_count     = CW'(acnt);
    b_base_addr = bbase;
    b_count     = CW'(bcnt);
  endtask

  task automatic run_job(input logic [AW-1:0] abase, input int acnt,
                         input logic [AW-1:0] bbase, input int bcnt,
                         input int apct, input int bpct, input int ablk, input int bblk,
                         input int glitch_k);
    init_job(abase, acnt, bbase, bcnt, apct, bpct, ablk, bblk);
    for (int k = 1; k <= 1500; k++) begin
      step(k, k == glitch_k);
      if (k == 10) dlv_b_at10 = dlv_b;
      if (done_cyc >= 0 && k >= done_cyc + 3) break;
    end
    check("done_once", done_cnt, 1);
    check("a_all_delivered", exp_a.size(), 0);
    check("b_all_delivered", exp_b.size(), 0);
    check("reads_total", iss_a + iss_b, acnt + bcnt);
  endtask

  initial begin
    arst_n_in = 1'b1; start = 1'b0;
    a_base_addr = '0; b_base_addr = '0; a_count = '0; b_count = '0;
    a_ready = 1'b0; b_ready = 1'b0; mem_qout = '0;
    #3;
    do_reset();

    // Basic A only
    mem_ovr[32'h100] = 16'd7;
    mem_ovr[32'h101] = 16'd8;
    mem_ovr[32'h102] = 16'd9;
    run_job(20'h00100, 3, 20'h80000, 0, 100, 100, 0, 0, 0);
    check("basic_first_a_valid_cycle", first_a_cyc, 3);

    // Arbitration from reset: A,B,A,B... in back-to-back cycles
    do_reset();
    run_job(20'h00200, 4, 20'h90000, 4, 100, 100, 0, 0, 0);
    check("arb_read_count", rd_tag.size(), 8);
    for (int i = 0; i < rd_tag.size() && i < 8; i++) begin
      check("arb_tag", rd_tag[i], i % 2);
      check("arb_cycle", rd_cyc[i], i + 1);
    end

    // Backpressure on A for 10 cycles
    run_job(20'h00300, 6, 20'hA0000, 6, 100, 100, 11, 0, 0);
    check("b_progress_while_a_blocked", dlv_b_at10 >= 3, 1);

    // Wrap-around and zero length
    run_job(20'hFFFFF, 2, 20'h50000, 0, 100, 100, 0, 0, 0);
    check("wrap_read_count", rd_addr.size(), 2);
    if (rd_addr.size() == 2) begin
      check("wrap_addr0", rd_addr[0], 20'hFFFFF);
      check("wrap_addr1", rd_addr[1], 20'h00000);
    end
    run_job(20'h12345, 0, 20'hABCDE, 0, 100, 100, 0, 0, 0);
    check("zero_done_cycle", done_cyc, 3);
    check("zero_no_reads", rd_tag.size(), 0);

    // Ignored start during STREAM
    run_job(20'h00600, 6, 20'hC0000, 6, 70, 70, 0, 0, 3);

    // Reset in the middle of a job
    init_job(20'h00700, 8, 20'hD0000, 8, 100, 100, 0, 0);
    for (int k = 1; k <= 4; k++) step(k, 1'b0);
    #2;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_running", running, 0);
      check("post_rst_a_valid", a_valid, 0);
      check("post_rst_b_valid", b_valid, 0);
    end

    // Stall counter: A held off for 5 cycles of valid
    run_job(20'h00400, 1, 20'hB0000, 0, 100, 100, 8, 0, 0);
    check("stats_a_stall", a_stall_cycles, STATS ? 5 : 0);
    check("stats_b_stall", b_stall_cycles, 0);

    // Randomised jobs, back to back without reset
    for (int j = 0; j < 8; j++) begin
      run_job(AW'($urandom_range(0, 32'h7FFC0)), $urandom_range(0, 12),
              AW'($urandom_range(32'h80000, 32'hFFFC0)), $urandom_range(0, 12),
              $urandom_range(30, 100), $urandom_range(30, 100), 0, 0,
              ($urandom_range(0, 1) == 1) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
